// File: rtl/ldpc_loop_bridge.sv
// ldpc_loop_bridge: decoder->encoder loopback with beat FIFO,
// per-packet encoder ctrl issue and status drain/id checking.
module ldpc_loop_bridge #(
    parameter int DATA_WIDTH = 128,
    parameter int CTRL_WIDTH = 40,
    parameter int FIFO_DEPTH = 64,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_enable,
    input  logic [2:0]            cfg_bg,
    input  logic [2:0]            cfg_z_set,
    input  logic [2:0]            cfg_z_j,
    input  logic [5:0]            cfg_mb,
    input  logic [2:0]            cfg_max_schedule,
    input  logic [DATA_WIDTH-1:0] m_axis_dout_tdata,
    input  logic                  m_axis_dout_tlast,
    input  logic                  m_axis_dout_tvalid,
    output logic                  m_axis_dout_tready,
    input  logic [CTRL_WIDTH-1:0] decoder_status_tdata,
    input  logic                  decoder_status_tvalid,
    output logic                  decoder_status_tready,
    output logic [DATA_WIDTH-1:0] s_axis_din_tdata,
    output logic                  s_axis_din_tlast,
    output logic                  s_axis_din_tvalid,
    input  logic                  s_axis_din_tready,
    output logic [CTRL_WIDTH-1:0] s_axis_ctrl_tdata,
    output logic                  s_axis_ctrl_tvalid,
    input  logic                  s_axis_ctrl_tready,
    input  logic [CTRL_WIDTH-1:0] encoder_status_tdata,
    input  logic                  encoder_status_tvalid,
    output logic                  encoder_status_tready,
    output logic [31:0]           pkt_count,
    output logic [31:0]           dec_status_count,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CTRL,
        DATA
    } state_t;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nx;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH:0]   head;
    state_t                state;
    logic [7:0]            next_id;
    logic [7:0]            exp_id;
    logic [7:0]            enc_id;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [CTRL_WIDTH-1:0] ctrl_nx;
    logic                  ctrl_valid_q;
    logic                  unused_bits;

    // Readies are gated by resetn so they read 0 while reset is held.
    assign m_axis_dout_tready    = resetn & ~fifo_full;
    assign decoder_status_tready = resetn;
    assign encoder_status_tready = resetn;

    assign wr_en = m_axis_dout_tvalid & m_axis_dout_tready;
    assign head  = mem[rd_ptr];

    assign s_axis_din_tvalid = (state == DATA) & ~fifo_empty;
    assign s_axis_din_tdata  = s_axis_din_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign s_axis_din_tlast  = s_axis_din_tvalid & head[DATA_WIDTH];
    assign rd_en = s_axis_din_tvalid & s_axis_din_tready;

    assign s_axis_ctrl_tvalid = ctrl_valid_q;
    assign s_axis_ctrl_tdata  = ctrl_q;

    assign enc_id      = encoder_status_tdata[30:23];
    assign unused_bits = ^{decoder_status_tdata, encoder_status_tdata};

    // Next occupancy from the write/read pair of this cycle.
    always_comb begin
        count_nx = count;
        unique case ({wr_en, rd_en})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    // Ctrl word assembled from live cfg; captured only when leaving IDLE.
    always_comb begin
        ctrl_nx        = '0;
        ctrl_nx[39:37] = cfg_max_schedule;
        ctrl_nx[36:31] = cfg_mb;
        ctrl_nx[30:23] = next_id;
        ctrl_nx[8:6]   = cfg_bg;
        ctrl_nx[5:3]   = cfg_z_set;
        ctrl_nx[2:0]   = cfg_z_j;
    end

    // Beat storage; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {m_axis_dout_tlast, m_axis_dout_tdata};
        end
    end

    // FIFO pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_nx;
            fifo_full  <= (count_nx == FULL_CNT);
            fifo_empty <= (count_nx == '0);
        end
    end

    // Packet sequencer: one ctrl word, then the packet's beats.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            next_id      <= 8'd0;
            pkt_count    <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_enable && !fifo_empty) begin
                        ctrl_q       <= ctrl_nx;
                        ctrl_valid_q <= 1'b1;
                        state        <= CTRL;
                    end
                end
                CTRL: begin
                    if (s_axis_ctrl_tready) begin
                        ctrl_valid_q <= 1'b0;
                        next_id      <= next_id + 8'd1;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (rd_en && head[DATA_WIDTH]) begin
                        pkt_count <= pkt_count + 32'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status drains: count decoder words, track encoder id sequence.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dec_status_count <= 32'd0;
            exp_id           <= 8'd0;
            err_count        <= '0;
        end else begin
            if (decoder_status_tvalid) begin
                dec_status_count <= dec_status_count + 32'd1;
            end
            if (encoder_status_tvalid) begin
                if (enc_id == exp_id) begin
                    exp_id <= exp_id + 8'd1;
                end else begin
                    exp_id <= enc_id + 8'd1;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ldpc_loop_bridge.sv
// tb_ldpc_loop_bridge: directed + random stimulus against a
// packet-level reference model of the loop bridge.
module tb_ldpc_loop_bridge;

    localparam int DW    = 128;
    localparam int CWD   = 40;
    localparam int DEPTH = 64;
    localparam int EW    = 16;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           cfg_enable;
    logic [2:0]     cfg_bg;
    logic [2:0]     cfg_z_set;
    logic [2:0]     cfg_z_j;
    logic [5:0]     cfg_mb;
    logic [2:0]     cfg_max_schedule;
    logic [DW-1:0]  dout_tdata;
    logic           dout_tlast;
    logic           dout_tvalid;
    logic           dout_tready;
    logic [CWD-1:0] dec_tdata;
    logic           dec_tvalid;
    logic           dec_tready;
    logic [DW-1:0]  din_tdata;
    logic           din_tlast;
    logic           din_tvalid;
    logic           din_tready;
    logic [CWD-1:0] ctrl_tdata;
    logic           ctrl_tvalid;
    logic           ctrl_tready;
    logic [CWD-1:0] enc_tdata;
    logic           enc_tvalid;
    logic           enc_tready;
    logic [31:0]    pkt_count;
    logic [31:0]    dec_count;
    logic [EW-1:0]  err_count;

    always #5 clk = ~clk;

    ldpc_loop_bridge #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CWD),
        .FIFO_DEPTH(DEPTH),
        .ERR_WIDTH(EW)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .cfg_enable           (cfg_enable),
        .cfg_bg               (cfg_bg),
        .cfg_z_set            (cfg_z_set),
        .cfg_z_j              (cfg_z_j),
        .cfg_mb               (cfg_mb),
        .cfg_max_schedule     (cfg_max_schedule),
        .m_axis_dout_tdata    (dout_tdata),
        .m_axis_dout_tlast    (dout_tlast),
        .m_axis_dout_tvalid   (dout_tvalid),
        .m_axis_dout_tready   (dout_tready),
        .decoder_status_tdata (dec_tdata),
        .decoder_status_tvalid(dec_tvalid),
        .decoder_status_tready(dec_tready),
        .s_axis_din_tdata     (din_tdata),
        .s_axis_din_tlast     (din_tlast),
        .s_axis_din_tvalid    (din_tvalid),
        .s_axis_din_tready    (din_tready),
        .s_axis_ctrl_tdata    (ctrl_tdata),
        .s_axis_ctrl_tvalid   (ctrl_tvalid),
        .s_axis_ctrl_tready   (ctrl_tready),
        .encoder_status_tdata (enc_tdata),
        .encoder_status_tvalid(enc_tvalid),
        .encoder_status_tready(enc_tready),
        .pkt_count            (pkt_count),
        .dec_status_count     (dec_count),
        .err_count            (err_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state (owned by the monitor).
    logic [DW:0]  bq[$];
    int           occ;
    bit           granted;
    bit           prev_idle;
    bit           prev_go;
    logic [39:0]  prev_word;
    bit           prev_cvalid;
    logic [39:0]  prev_cdata;
    logic [39:0]  last_word;
    bit           prev_dvalid;
    int           m_pkt;
    int           m_dec;
    int           m_err;
    logic [7:0]   m_exp;
    logic [7:0]   m_id;
    int           n_ctrl = 0;
    int           n_din = 0;
    int           first_wr;
    int           first_ctrl;
    int           first_din;
    int           last_tlast_cyc = -1;
    int           gap_min;
    int           gap_max;
    logic [DW:0]  mb_beat;
    logic [7:0]   mb_id;
    bit           g0;
    int           occ0;
    int           gap;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [2:0] sch,
                                       input logic [5:0] mb,
                                       input logic [7:0] id,
                                       input logic [2:0] bg,
                                       input logic [2:0] zs,
                                       input logic [2:0] zj);
        return {sch, mb, id, 14'd0, bg, zs, zj};
    endfunction

    function automatic logic [DW-1:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every cycle against the model, then advances it.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_flags", {ctrl_tvalid, din_tvalid, din_tlast,
                dout_tready, dec_tready, enc_tready}, 0);
            chk("rst_din_data", din_tdata, 0);
            chk("rst_ctrl_data", ctrl_tdata, 0);
            chk("rst_counts", {pkt_count, dec_count, err_count}, 0);
            bq.delete();
            occ = 0;
            granted = 0;
            prev_idle = 0;
            prev_go = 0;
            prev_cvalid = 0;
            prev_dvalid = 0;
            m_pkt = 0;
            m_dec = 0;
            m_err = 0;
            m_exp = 0;
            m_id = 0;
            first_wr = -1;
            first_ctrl = -1;
            first_din = -1;
        end else begin
            g0 = granted;
            occ0 = occ;
            chk("status_readys", {dec_tready, enc_tready}, 2'b11);
            chk("pkt_count", pkt_count, m_pkt);
            chk("dec_status_count", dec_count, m_dec);
            chk("err_count", err_count, m_err);
            chk("dout_tready", dout_tready, occ0 != DEPTH);
            if (prev_idle) begin
                chk("ctrl_start", ctrl_tvalid, prev_go);
            end
            if (ctrl_tvalid) begin
                chk("ctrl_origin", prev_idle | prev_cvalid, 1);
                chk("ctrl_in_data", g0, 0);
                if (prev_idle) begin
                    chk("ctrl_word", ctrl_tdata, prev_word);
                end else if (prev_cvalid) begin
                    chk("ctrl_hold", ctrl_tdata, prev_cdata);
                end
                if (first_ctrl < 0) first_ctrl = cyc;
            end
            chk("din_tvalid", din_tvalid, g0 && (occ0 > 0));
            if (din_tvalid) begin
                if (first_din < 0) first_din = cyc;
                if (!prev_dvalid && last_tlast_cyc >= 0) begin
                    gap = cyc - last_tlast_cyc;
                    if (gap < gap_min) gap_min = gap;
                    if (gap > gap_max) gap_max = gap;
                end
            end
            prev_idle = !g0 && !ctrl_tvalid;
            prev_go = cfg_enable && (occ0 > 0);
            prev_word = mk(cfg_max_schedule, cfg_mb, m_id,
                           cfg_bg, cfg_z_set, cfg_z_j);
            if (din_tvalid && din_tready) begin
                if (bq.size() > 0) begin
                    mb_beat = bq.pop_front();
                    chk("din_beat", {din_tlast, din_tdata}, mb_beat);
                end
                n_din++;
                if (din_tlast) begin
                    m_pkt++;
                    granted = 0;
                    last_tlast_cyc = cyc;
                end
            end
            if (ctrl_tvalid && ctrl_tready) begin
                granted = 1;
                m_id = m_id + 8'd1;
                n_ctrl++;
                last_word = ctrl_tdata;
            end
            prev_cvalid = ctrl_tvalid && !ctrl_tready;
            prev_cdata = ctrl_tdata;
            if (dout_tvalid && dout_tready) begin
                bq.push_back({dout_tlast, dout_tdata});
                if (first_wr < 0) first_wr = cyc;
            end
            occ = bq.size();
            if (dec_tvalid) m_dec++;
            if (enc_tvalid) begin
                mb_id = enc_tdata[30:23];
                if (mb_id == m_exp) begin
                    m_exp = m_exp + 8'd1;
                end else begin
                    if (m_err < 65535) m_err++;
                    m_exp = mb_id + 8'd1;
                end
            end
            prev_dvalid = din_tvalid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        int n;
        logic hs;
        n = 0;
        hs = 0;
        dout_tdata = d;
        dout_tlast = l;
        dout_tvalid = 1;
        while (!hs && n < 2000) begin
            @(negedge clk);
            hs = dout_tready;
            @(posedge clk);
            #1;
            n++;
        end
        dout_tvalid = 0;
        chk("push_timeout", hs, 1);
    endtask

    task automatic wait_pkts(input int target, input int bound);
        int n;
        n = 0;
        while (m_pkt < target && n < bound) begin
            tick();
            n++;
        end
        chk("wait_pkts", m_pkt >= target, 1);
        repeat (2) tick();
    endtask

    task automatic wait_grant(input int bound);
        int n;
        n = 0;
        while (!granted && n < bound) begin
            tick();
            n++;
        end
        chk("wait_grant", granted, 1);
    endtask

    task automatic send_enc(input logic [7:0] id);
        enc_tdata = '0;
        enc_tdata[30:23] = id;
        enc_tvalid = 1;
        tick();
        enc_tvalid = 0;
    endtask

    bit done;
    int c0;
    int p0;
    int len;
    int nw;

    initial begin
        cfg_enable = 0;
        cfg_bg = 0;
        cfg_z_set = 0;
        cfg_z_j = 0;
        cfg_mb = 0;
        cfg_max_schedule = 0;
        dout_tdata = '0;
        dout_tlast = 0;
        dout_tvalid = 0;
        dec_tdata = '0;
        dec_tvalid = 0;
        din_tready = 0;
        ctrl_tready = 0;
        enc_tdata = '0;
        enc_tvalid = 0;
        repeat (3) tick();
        resetn = 1;

        // 1: single 3-beat packet, literal ctrl word and latency
        cfg_bg = 3'd1;
        cfg_z_set = 3'd2;
        cfg_z_j = 3'd3;
        cfg_mb = 6'd4;
        cfg_max_schedule = 3'd5;
        cfg_enable = 1;
        din_tready = 1;
        ctrl_tready = 1;
        tick();
        for (int i = 0; i < 3; i++) push(r128(), i == 2);
        wait_pkts(1, 50);
        chk("t1_ctrl_word", last_word, 40'hA2_0000_0053);
        chk("t1_lat_ctrl", first_ctrl - first_wr, 2);
        chk("t1_lat_din", first_din - first_wr, 3);
        chk("t1_pkt_count", pkt_count, 1);
        chk("t1_din_beats", n_din, 3);

        // 2: fill FIFO to depth with din stalled, then drain
        din_tready = 0;
        for (int i = 0; i < DEPTH; i++) push(r128(), i == DEPTH - 1);
        tick();
        chk("t2_full_tready", dout_tready, 0);
        chk("t2_occ", occ, DEPTH);
        c0 = n_din;
        din_tready = 1;
        wait_pkts(2, 300);
        chk("t2_drained", n_din - c0, DEPTH);

        // 3: 257 one-beat packets, id wrap and inter-packet gap
        resetn = 0;
        repeat (2) tick();
        resetn = 1;
        tick();
        gap_min = 1000;
        gap_max = 0;
        last_tlast_cyc = -1;
        c0 = n_ctrl;
        for (int i = 0; i < 257; i++) push(r128(), 1);
        wait_pkts(257, 3000);
        chk("t3_pkt_count", pkt_count, 257);
        chk("t3_ctrls", n_ctrl - c0, 257);
        chk("t3_last_id", last_word[30:23], 0);
        chk("t3_gap_min", gap_min, 3);
        chk("t3_gap_max", gap_max, 3);

        // 4: status streams, id checking and saturation
        dec_tvalid = 1;
        repeat (10) tick();
        dec_tvalid = 0;
        tick();
        chk("t4_dec_count", dec_count, 10);
        send_enc(8'd0);
        send_enc(8'd1);
        send_enc(8'd5);
        send_enc(8'd6);
        tick();
        chk("t4_err_one", err_count, 1);
        enc_tdata = '0;
        enc_tdata[30:23] = 8'd7;
        enc_tvalid = 1;
        repeat (65541) tick();
        enc_tvalid = 0;
        tick();
        chk("t4_err_sat", err_count, 16'hFFFF);

        // 5: cfg change and disable mid-packet
        cfg_bg = 3'd2;
        cfg_enable = 1;
        din_tready = 0;
        for (int i = 0; i < 4; i++) push(r128(), i == 3);
        wait_grant(50);
        cfg_bg = 3'd7;
        cfg_enable = 0;
        c0 = n_ctrl;
        p0 = m_pkt;
        push(r128(), 1);
        din_tready = 1;
        repeat (20) tick();
        chk("t5_no_new_ctrl", n_ctrl - c0, 0);
        chk("t5_pkt_done", pkt_count, p0 + 1);
        chk("t5_old_bg", last_word[8:6], 3'd2);
        chk("t5_pending", occ, 1);
        cfg_enable = 1;
        repeat (10) tick();
        chk("t5_new_bg", last_word[8:6], 3'd7);
        chk("t5_pkt_next", pkt_count, p0 + 2);

        // 6: reset in the middle of a packet
        din_tready = 0;
        for (int i = 0; i < 5; i++) push(r128(), i == 4);
        wait_grant(50);
        din_tready = 1;
        tick();
        resetn = 0;
        #1;
        chk("t6_flags", {ctrl_tvalid, din_tvalid, din_tlast,
            dout_tready, dec_tready, enc_tready}, 0);
        chk("t6_din_data", din_tdata, 0);
        chk("t6_counts", {pkt_count, dec_count, err_count}, 0);
        repeat (2) tick();
        resetn = 1;
        c0 = n_din;
        repeat (3) tick();
        chk("t6_fifo_empty", n_din - c0, 0);
        push(r128(), 1);
        wait_pkts(1, 50);
        chk("t6_id_zero", last_word[30:23], 0);
        chk("t6_one_beat", n_din - c0, 1);
        chk("t6_pkt_count", pkt_count, 1);

        // 7: randomized traffic on all streams
        done = 0;
        fork
            begin
                for (int p = 0; p < 150; p++) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        push(r128(), b == len - 1);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    din_tready = ($urandom_range(0, 3) != 0);
                    ctrl_tready = $urandom_range(0, 1);
                    cfg_bg = 3'($urandom);
                    cfg_z_set = 3'($urandom);
                    cfg_z_j = 3'($urandom);
                    cfg_mb = 6'($urandom);
                    cfg_max_schedule = 3'($urandom);
                    if ($urandom_range(0, 9) == 0) cfg_enable = ~cfg_enable;
                    tick();
                end
            end
            begin
                while (!done) begin
                    dec_tvalid = $urandom_range(0, 1);
                    dec_tdata = 40'({$urandom, $urandom});
                    enc_tvalid = ($urandom_range(0, 2) == 0);
                    enc_tdata = 40'({$urandom, $urandom});
                    if ($urandom_range(0, 4) != 0) enc_tdata[30:23] = m_exp;
                    tick();
                end
            end
        join
        cfg_enable = 1;
        din_tready = 1;
        ctrl_tready = 1;
        dec_tvalid = 0;
        enc_tvalid = 0;
        nw = 0;
        while ((occ > 0 || granted || ctrl_tvalid) && nw < 3000) begin
            tick();
            nw++;
        end
        chk("t7_drained", occ, 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
